// File: rtl/snake_pkg.sv
// snake_pkg: shared state encoding, tile geometry and default sizing for snake_control.
package snake_pkg;

  localparam int TILE_PIXELS     = 16;
  localparam int SEG_W           = 11;
  localparam int DEF_TICK_CYCLES = 5000000;
  localparam int DEF_INIT_LEN    = 4;
  localparam int DEF_MAX_LEN     = 2047;
  localparam int DEF_RAM_DEPTH   = 2048;

  typedef enum logic [4:0] {
    S_CLEAR,
    S_CLR_ADDR,
    S_CLR_RAM,
    S_INIT_HEAD,
    S_INIT,
    S_READY,
    S_WAIT,
    S_STEP,
    S_UPD,
    S_RD,
    S_LATCH,
    S_WR,
    S_NXT,
    S_ERASE,
    S_DRAW_ADDR,
    S_DRAW_RD,
    S_DRAW,
    S_DRAW_NXT,
    S_APPLE,
    S_CHECK,
    S_DEAD
  } state_t;

endpackage

// File: rtl/snake_step_timer.sv
// snake_step_timer: loads TICK_CYCLES-1 on entry to a run window, counts down, pulses done at zero.
module snake_step_timer
  import snake_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic done
);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] count;
  logic          armed;

  assign done = run && armed && (count == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      armed <= 1'b0;
    end else if (!run) begin
      count <= '0;
      armed <= 1'b0;
    end else if (!armed) begin
      count <= CW'(TICK_CYCLES - 1);
      armed <= 1'b1;
    end else if (count == '0) begin
      armed <= 1'b0;
    end else begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/snake_control.sv
// snake_control: game sequencer driving the snake datapath (clear, init, timed step, render, check).
// Tail growth on apple hits is compiled in only when SNAKE_GROWTH_EN is defined.
//
// state              | meaning
// S_CLEAR            | quiescent entry after reset or restart
// S_CLR_ADDR/CLR_RAM | address reset, then RAM wipe over RAM_DEPTH words
// S_INIT_HEAD/INIT   | default head, then INIT_LEN segments written
// S_READY/S_WAIT     | wait for go / wait for step tick
// S_STEP/S_UPD       | head copied to prev, head advanced
// S_RD..S_NXT        | per-segment shift: read, latch, write, advance
// S_ERASE            | blank the old tail tile
// S_DRAW_*           | per-segment tile render
// S_APPLE/CHECK/DEAD | apple render, collision check, game over
module snake_control
  import snake_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int INIT_LEN    = DEF_INIT_LEN,
  parameter int MAX_LEN     = DEF_MAX_LEN,
  parameter int RAM_DEPTH   = DEF_RAM_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       isDead,
  input  logic       good_collision,
  output logic       reset_address,
  output logic       inc_address,
  output logic       reset_ram,
  output logic       load_default_head,
  output logic       load_part_into_ram,
  output logic       load_head_into_prev,
  output logic       update_head,
  output logic       load_ram_into_current,
  output logic       load_prev_into_ram,
  output logic       load_current_into_prev,
  output logic       erase_trail,
  output logic       draw_ram,
  output logic       draw_apple,
  output logic       inc_check,
  output logic [3:0] drawStatus,
  output logic       game_over
);
  localparam int CNT_W = $clog2(RAM_DEPTH + 1);

  state_t           state, state_nxt;
  logic [SEG_W-1:0] seg_idx, len;
  logic [CNT_W-1:0] clr_cnt;
  logic [3:0]       px;
  logic             go_q, skip_erase, tick_done, last_seg, px_last, timer_run;

  assign last_seg   = (seg_idx == len - SEG_W'(1));
  assign px_last    = (px == 4'(TILE_PIXELS - 1));
  assign drawStatus = px;
  assign timer_run  = (state == S_WAIT);

  snake_step_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
    .clk  (clk),
    .reset(reset),
    .run  (timer_run),
    .done (tick_done)
  );

`ifndef SNAKE_GROWTH_EN
  logic unused_gc;
  assign unused_gc = good_collision;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_CLEAR;
      seg_idx    <= '0;
      clr_cnt    <= '0;
      px         <= '0;
      go_q       <= 1'b0;
      len        <= SEG_W'(INIT_LEN);
      skip_erase <= 1'b0;
    end else begin
      state   <= state_nxt;
      go_q    <= go;
      clr_cnt <= (state == S_CLR_RAM) ? clr_cnt + CNT_W'(1) : '0;
      px      <= (erase_trail || draw_ram || draw_apple) ? px + 4'd1 : 4'd0;
      if (reset_address)
        seg_idx <= '0;
      else if (inc_address && (seg_idx < SEG_W'(MAX_LEN)))
        seg_idx <= seg_idx + SEG_W'(1);
`ifdef SNAKE_GROWTH_EN
      // a grown tail reuses the cell that would have been erased
      if (state == S_CLEAR) begin
        len        <= SEG_W'(INIT_LEN);
        skip_erase <= 1'b0;
      end else if (state == S_CHECK && good_collision && (len < SEG_W'(MAX_LEN))) begin
        len        <= len + SEG_W'(1);
        skip_erase <= 1'b1;
      end else if (state == S_DRAW_ADDR) begin
        skip_erase <= 1'b0;
      end
`else
      len        <= SEG_W'(INIT_LEN);
      skip_erase <= 1'b0;
`endif
    end
  end

  always_comb begin
    state_nxt              = state;
    reset_address          = 1'b0;
    inc_address            = 1'b0;
    reset_ram              = 1'b0;
    load_default_head      = 1'b0;
    load_part_into_ram     = 1'b0;
    load_head_into_prev    = 1'b0;
    update_head            = 1'b0;
    load_ram_into_current  = 1'b0;
    load_prev_into_ram     = 1'b0;
    load_current_into_prev = 1'b0;
    erase_trail            = 1'b0;
    draw_ram               = 1'b0;
    draw_apple             = 1'b0;
    inc_check              = 1'b0;
    game_over              = 1'b0;
    unique case (state)
      S_CLEAR:     state_nxt = S_CLR_ADDR;
      S_CLR_ADDR: begin
        reset_address = 1'b1;
        state_nxt     = S_CLR_RAM;
      end
      S_CLR_RAM: begin
        reset_ram   = 1'b1;
        inc_address = 1'b1;
        if (clr_cnt == CNT_W'(RAM_DEPTH - 1)) state_nxt = S_INIT_HEAD;
      end
      S_INIT_HEAD: begin
        load_default_head = 1'b1;
        reset_address     = 1'b1;
        state_nxt         = S_INIT;
      end
      S_INIT: begin
        load_part_into_ram = 1'b1;
        inc_address        = 1'b1;
        if (last_seg) state_nxt = S_READY;
      end
      S_READY:     if (go) state_nxt = S_WAIT;
      S_WAIT:      if (tick_done) state_nxt = S_STEP;
      S_STEP: begin
        load_head_into_prev = 1'b1;
        reset_address       = 1'b1;
        state_nxt           = S_UPD;
      end
      S_UPD: begin
        update_head = 1'b1;
        state_nxt   = S_RD;
      end
      S_RD:        state_nxt = S_LATCH;
      S_LATCH: begin
        load_ram_into_current = 1'b1;
        state_nxt             = S_WR;
      end
      S_WR: begin
        load_prev_into_ram = 1'b1;
        state_nxt          = S_NXT;
      end
      S_NXT: begin
        load_current_into_prev = 1'b1;
        inc_address            = 1'b1;
        if (!last_seg)       state_nxt = S_RD;
        else if (skip_erase) state_nxt = S_DRAW_ADDR;
        else                 state_nxt = S_ERASE;
      end
      S_ERASE: begin
        erase_trail = 1'b1;
        if (px_last) state_nxt = S_DRAW_ADDR;
      end
      S_DRAW_ADDR: begin
        reset_address = 1'b1;
        state_nxt     = S_DRAW_RD;
      end
      S_DRAW_RD:   state_nxt = S_DRAW;
      S_DRAW: begin
        draw_ram = 1'b1;
        if (px_last) state_nxt = S_DRAW_NXT;
      end
      S_DRAW_NXT: begin
        inc_address = 1'b1;
        state_nxt   = last_seg ? S_APPLE : S_DRAW_RD;
      end
      S_APPLE: begin
        draw_apple = 1'b1;
        if (px_last) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        inc_check = 1'b1;
        state_nxt = isDead ? S_DEAD : S_WAIT;
      end
      S_DEAD: begin
        game_over = 1'b1;
        if (go && !go_q) state_nxt = S_CLEAR;
      end
      default:     state_nxt = S_CLEAR;
    endcase
  end

endmodule

// File: tb/tb_snake_control.sv
// tb_snake_control: randomized game steps checked against per-step strobe budgets from a length model.
module tb_snake_control;
  localparam int TICK  = 4;
  localparam int INIT  = 4;
  localparam int MAXL  = 5;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic       isDead = 1'b0;
  logic       good_collision = 1'b0;
  logic       reset_address, inc_address, reset_ram, load_default_head, load_part_into_ram;
  logic       load_head_into_prev, update_head, load_ram_into_current, load_prev_into_ram;
  logic       load_current_into_prev, erase_trail, draw_ram, draw_apple, inc_check, game_over;
  logic [3:0] drawStatus;

  int vectors = 0;
  int miscompares = 0;
  int m_len = INIT;
  bit m_skip = 1'b0;

  always #5 clk = ~clk;

  snake_control #(
    .TICK_CYCLES(TICK), .INIT_LEN(INIT), .MAX_LEN(MAXL), .RAM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .isDead(isDead), .good_collision(good_collision),
    .reset_address(reset_address), .inc_address(inc_address), .reset_ram(reset_ram),
    .load_default_head(load_default_head), .load_part_into_ram(load_part_into_ram),
    .load_head_into_prev(load_head_into_prev), .update_head(update_head),
    .load_ram_into_current(load_ram_into_current), .load_prev_into_ram(load_prev_into_ram),
    .load_current_into_prev(load_current_into_prev), .erase_trail(erase_trail),
    .draw_ram(draw_ram), .draw_apple(draw_apple), .inc_check(inc_check),
    .drawStatus(drawStatus), .game_over(game_over)
  );

  wire [14:0] outs = {reset_address, inc_address, reset_ram, load_default_head, load_part_into_ram,
                      load_head_into_prev, update_head, load_ram_into_current, load_prev_into_ram,
                      load_current_into_prev, erase_trail, draw_ram, draw_apple, inc_check, game_over};

  task automatic chk_val(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every cycle: exclusive data-path strobes, and drawStatus counts through each render run.
  int run_len = 0;
  int prev_kind = 0;
  always @(negedge clk) begin : mon
    int kind;
    int pop;
    pop = int'(reset_ram) + int'(load_part_into_ram) + int'(load_prev_into_ram) +
          int'(draw_ram) + int'(erase_trail) + int'(draw_apple);
    chk_val("one_hot", int'(pop > 1), 0);
    kind = erase_trail ? 1 : draw_ram ? 2 : draw_apple ? 3 : 0;
    if (kind != 0 && kind == prev_kind) run_len = run_len + 1;
    else run_len = 0;
    prev_kind = kind;
    chk_val("draw_status", int'(drawStatus), (kind != 0) ? (run_len % 16) : 0);
  end

  task automatic init_window();
    int n_rr, n_lp, n_head, rr_runs;
    bit prev_rr;
    n_rr = 0; n_lp = 0; n_head = 0; rr_runs = 0; prev_rr = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_rr   += int'(reset_ram);
      n_lp   += int'(load_part_into_ram);
      n_head += int'(load_default_head);
      if (reset_ram && !prev_rr) rr_runs++;
      prev_rr = reset_ram;
    end
    chk_val("clear_cycles", n_rr, DEPTH);
    chk_val("clear_runs", rr_runs, 1);
    chk_val("init_cycles", n_lp, INIT);
    chk_val("init_head", n_head, 1);
    m_len  = INIT;
    m_skip = 1'b0;
  endtask

  // mode: 0..3 plain, 4 isDead pulse inside shift loop only, 5 die, 6 reset mid-draw
  task automatic run_step(input int mode, input bit gc, output bit died, output bit aborted);
    int n_prev, n_cur, n_upd, n_erase, n_draw, n_apple, n_chk;
    bit done, dead_at_chk;
    n_prev = 0; n_cur = 0; n_upd = 0; n_erase = 0; n_draw = 0; n_apple = 0; n_chk = 0;
    done = 1'b0; dead_at_chk = 1'b0; died = 1'b0; aborted = 1'b0;
    good_collision = gc;
    for (int c = 0; c < 800 && !done; c++) begin
      @(negedge clk);
      n_prev  += int'(load_prev_into_ram);
      n_cur   += int'(load_ram_into_current);
      n_upd   += int'(update_head);
      n_erase += int'(erase_trail);
      n_draw  += int'(draw_ram);
      n_apple += int'(draw_apple);
      n_chk   += int'(inc_check);
      if (load_prev_into_ram && (mode == 4 || mode == 5)) isDead = 1'b1;
      if (draw_ram && mode == 4) isDead = 1'b0;
      if (draw_ram && mode == 6 && n_draw == 5) begin
        reset = 1'b0;
        go = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          chk_val("rst_outs", int'(outs), 0);
          chk_val("rst_ds", int'(drawStatus), 0);
        end
        reset = 1'b1;
        aborted = 1'b1;
        return;
      end
      if (inc_check) begin
        done = 1'b1;
        dead_at_chk = isDead;
      end
    end
    chk_val("step_done", int'(done), 1);
    chk_val("n_prev_to_ram", n_prev, m_len);
    chk_val("n_ram_to_cur", n_cur, m_len);
    chk_val("n_update_head", n_upd, 1);
    chk_val("n_erase", n_erase, m_skip ? 0 : 16);
    chk_val("n_draw_ram", n_draw, 16 * m_len);
    chk_val("n_draw_apple", n_apple, 16);
    chk_val("n_inc_check", n_chk, 1);
`ifdef SNAKE_GROWTH_EN
    if (gc && m_len < MAXL) begin
      m_len  = m_len + 1;
      m_skip = 1'b1;
    end else begin
      m_skip = 1'b0;
    end
`else
    m_skip = 1'b0;
`endif
    @(negedge clk);
    chk_val("game_over", int'(game_over), int'(dead_at_chk));
    died = dead_at_chk;
    isDead = 1'b0;
  endtask

  initial begin : main
    bit died, aborted, gc;
    int mode;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_val("reset_outs", int'(outs), 0);
    chk_val("reset_ds", int'(drawStatus), 0);
    reset = 1'b1;
    init_window();
    go = 1'b1;
    for (int s = 0; s < 16; s++) begin
      gc = (s < 3) ? 1'b1 : 1'($urandom_range(0, 1));
      if (s == 4)                 mode = 4;
      else if (s == 6 || s == 13) mode = 5;
      else if (s == 9)            mode = 6;
      else if (s < 4)             mode = 0;
      else                        mode = int'($urandom_range(0, 4));
      run_step(mode, gc, died, aborted);
      if (aborted) begin
        init_window();
        go = 1'b1;
      end else if (died) begin
        repeat (4) @(negedge clk);
        chk_val("dead_hold", int'(outs), 1);
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk_val("restart_outs", int'(outs), 0);
        init_window();
        go = 1'b1;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snake_control.md
SNAKE_CONTROL -- requirements
Module: snake_control

Interface
REQ-001 Parameter TICK_CYCLES, default 5000000, idle clk cycles between game steps.
REQ-002 Parameter INIT_LEN, default 4, initial snake segment count, including the head.
REQ-003 Parameter MAX_LEN, default 2047, cap on segment count.
REQ-004 Parameter RAM_DEPTH, default 2048, number of snake RAM words cleared at start.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 go  input  1  level; starts play from S_READY.
REQ-008 isDead  input  1  datapath death flag.
REQ-009 good_collision  input  1  datapath apple hit; valid only while inc_check is high.
REQ-010 reset_address, inc_address, reset_ram, load_default_head, load_part_into_ram  output  1 each  init strobes.
REQ-011 load_head_into_prev, update_head, load_ram_into_current, load_prev_into_ram, load_current_into_prev  output  1 each  shift strobes.
REQ-012 erase_trail, draw_ram, draw_apple, inc_check  output  1 each  render/check strobes.
REQ-013 drawStatus  output  4  pixel index within the 4x4 tile (0..15).
REQ-014 game_over  output  1  high while in S_DEAD.

Function
REQ-015 All strobes SHALL be Moore outputs decoded from state; at most one of reset_ram, load_part_into_ram, load_prev_into_ram, draw_ram, erase_trail, draw_apple SHALL be high per cycle.
REQ-016 Internal seg_idx[10:0] SHALL mirror datapath address: cleared with reset_address, +1 with inc_address, never exceeding MAX_LEN.
REQ-017 S_CLEAR: reset_address for 1 cycle, then reset_ram + inc_address for exactly RAM_DEPTH cycles.
REQ-018 S_INIT: load_default_head + reset_address for 1 cycle, then load_part_into_ram + inc_address for len = INIT_LEN cycles, then go to S_READY.
REQ-019 S_READY: hold until go=1; the step-timer SHALL start at 0.
REQ-020 S_WAIT: count TICK_CYCLES-1 down to 0, then go to S_STEP.
REQ-021 S_STEP: load_head_into_prev + reset_address (1 cycle), then update_head (1 cycle).
REQ-022 Shift loop, per segment 0..len-1: S_RD (no strobe, RAM read latency), S_LATCH load_ram_into_current, S_WR load_prev_into_ram, S_NXT load_current_into_prev + inc_address.
REQ-023 After the last segment: S_ERASE asserts erase_trail for 16 cycles with drawStatus 0..15.
REQ-024 Draw loop: reset_address; per segment, S_RD one cycle, then draw_ram for 16 cycles with drawStatus 0..15, then inc_address.
REQ-025 S_APPLE: draw_apple for 16 cycles with drawStatus 0..15.
REQ-026 S_CHECK: inc_check for 1 cycle; sample good_collision in the same cycle.
REQ-027 After S_CHECK: isDead=1 -> S_DEAD; otherwise -> S_WAIT.
REQ-028 drawStatus SHALL be 0 outside the three 16-cycle render states and SHALL wrap 15->0 on leaving each.
REQ-029 S_DEAD: game_over=1, all strobes 0; go rising edge -> S_CLEAR.
REQ-030 isDead asserted mid-loop SHALL NOT abort the current step; it is acted on only in S_CHECK.

Reset
REQ-031 reset=0 at a clock edge SHALL force S_CLEAR, seg_idx=0, drawStatus=0, timer=0, len=INIT_LEN, and all outputs 0 on the next cycle, regardless of the current state.

Configuration
REQ-032 With SNAKE_GROWTH_EN defined: good_collision=1 in S_CHECK SHALL set len=len+1, saturating at MAX_LEN; the new tail takes the erased coordinate, so no erase occurs on the next step.
REQ-033 Without SNAKE_GROWTH_EN: len SHALL stay INIT_LEN; good_collision is ignored by this block.

Structure
REQ-034 Package snake_pkg SHALL hold the state enum, the TILE_PIXELS=16 constant, and the default parameter constants.
REQ-035 Sub-module snake_step_timer (TICK_CYCLES down-counter with a done pulse) SHALL be instantiated once.

Verification
REQ-036 Reset held 2 cycles mid-S_DRAW -> S_CLEAR next cycle, all strobes 0, drawStatus=0.
REQ-037 RAM_DEPTH=8: after reset release -> reset_ram high exactly 8 cycles, then load_part_into_ram high exactly 4 cycles.
REQ-038 TICK_CYCLES=4, go=1, INIT_LEN=4 -> 4 load_prev_into_ram pulses, 16 erase_trail cycles, 64 draw_ram cycles, 16 draw_apple cycles, 1 inc_check per step.
REQ-039 isDead=1 during the shift loop -> step completes, game_over=1 after S_CHECK; go pulse -> S_CLEAR.
REQ-040 SNAKE_GROWTH_EN with good_collision=1 at S_CHECK -> next step shows 5 load_prev_into_ram pulses and 80 draw_ram cycles; without the macro -> still 4 and 64.
REQ-041 MAX_LEN=5, growth enabled, 3 apple hits -> len saturates at 5.
